// File: rtl/paddle_color_tracker.sv
// ============================================================================
// paddle_color_tracker : per-frame colour-threshold bounding box of the paddle
// Revision: 1.0
// ============================================================================
`default_nettype none

module paddle_color_tracker #(
  parameter int unsigned ROWS       = 480,
  parameter int unsigned COLS       = 640,
  parameter logic [7:0]  R_MIN      = 8'd160,
  parameter logic [7:0]  G_MAX      = 8'd80,
  parameter logic [7:0]  B_MAX      = 8'd80,
  parameter logic [19:0] MIN_PIXELS = 20'd64
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        newFrame,
  input  logic        pixel_valid,
  input  logic [12:0] row,
  input  logic [12:0] col,
  input  logic [7:0]  R,
  input  logic [7:0]  G,
  input  logic [7:0]  B,
  output logic [12:0] paddleLeft,
  output logic [12:0] paddleRight,
  output logic [12:0] paddleTop,
  output logic [12:0] paddleBottom,
  output logic [12:0] cRow,
  output logic [12:0] cCol,
  output logic        found,
  output logic [19:0] pixel_count,
  output logic        frame_done
);

  localparam logic [12:0] ROW_LIM  = 13'(ROWS);
  localparam logic [12:0] COL_LIM  = 13'(COLS);
  localparam logic [12:0] MIN_INIT = 13'h1FFF;
  localparam logic [19:0] CNT_SAT  = 20'hFFFFF;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    LATCH = 2'd2
  } state_t;

  state_t      state;
  logic [12:0] min_row, max_row, min_col, max_col;
  logic [19:0] cnt;

  logic        match;
  logic        clear;
  logic        take;
  logic [12:0] base_min_row, base_max_row, base_min_col, base_max_col;
  logic [19:0] base_cnt;
  logic [12:0] nxt_min_row, nxt_max_row, nxt_min_col, nxt_max_col;
  logic [19:0] nxt_cnt;
  logic [13:0] row_sum, col_sum;

  assign match = pixel_valid && (row < ROW_LIM) && (col < COL_LIM) &&
                 (R >= R_MIN) && (G <= G_MAX) && (B <= B_MAX);

  // The frame boundary cycle publishes the old box and starts the new frame
  // from cleared accumulators, so a coincident match belongs to the new frame.
  assign clear = (state != LATCH) && newFrame;
  assign take  = match && (state != IDLE || newFrame);

  always_comb begin
    base_min_row = clear ? MIN_INIT : min_row;
    base_max_row = clear ? 13'd0    : max_row;
    base_min_col = clear ? MIN_INIT : min_col;
    base_max_col = clear ? 13'd0    : max_col;
    base_cnt     = clear ? 20'd0    : cnt;
    nxt_min_row  = base_min_row;
    nxt_max_row  = base_max_row;
    nxt_min_col  = base_min_col;
    nxt_max_col  = base_max_col;
    nxt_cnt      = base_cnt;
    if (take) begin
      if (row < base_min_row) nxt_min_row = row;
      if (row > base_max_row) nxt_max_row = row;
      if (col < base_min_col) nxt_min_col = col;
      if (col > base_max_col) nxt_max_col = col;
      if (base_cnt != CNT_SAT) nxt_cnt = base_cnt + 20'd1;
    end
  end

  assign row_sum = {1'b0, min_row} + {1'b0, max_row};
  assign col_sum = {1'b0, min_col} + {1'b0, max_col};

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= IDLE;
      min_row      <= MIN_INIT;
      max_row      <= 13'd0;
      min_col      <= MIN_INIT;
      max_col      <= 13'd0;
      cnt          <= 20'd0;
      paddleLeft   <= 13'd0;
      paddleRight  <= 13'd0;
      paddleTop    <= 13'd0;
      paddleBottom <= 13'd0;
      cRow         <= 13'd0;
      cCol         <= 13'd0;
      found        <= 1'b0;
      pixel_count  <= 20'd0;
      frame_done   <= 1'b0;
    end else begin
      min_row    <= nxt_min_row;
      max_row    <= nxt_max_row;
      min_col    <= nxt_min_col;
      max_col    <= nxt_max_col;
      cnt        <= nxt_cnt;
      frame_done <= 1'b0;
      case (state)
        IDLE: begin
          if (newFrame) state <= ACCUM;
        end
        ACCUM: begin
          if (newFrame) begin
            state       <= LATCH;
            frame_done  <= 1'b1;
            pixel_count <= cnt;
            if (cnt >= MIN_PIXELS) begin
              paddleLeft   <= min_col;
              paddleRight  <= max_col;
              paddleTop    <= min_row;
              paddleBottom <= max_row;
              cRow         <= row_sum[13:1];
              cCol         <= col_sum[13:1];
              found        <= 1'b1;
            end else begin
              found        <= 1'b0;
            end
          end
        end
        LATCH: begin
          state <= ACCUM;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

`default_nettype wire
